// File: rtl/estagio_wb_pkg.sv
// Shared widths, queue state encoding and the pending-write payload for the write-back stage.
package estagio_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned FILA_CW = 2;

  // Occupancy of the 2-entry pending-write queue; the encoding doubles as the entry count.
  typedef enum logic [FILA_CW-1:0] {
    VAZIA = 2'd0,
    UMA   = 2'd1,
    CHEIA = 2'd2
  } fila_estado_e;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] dado;
  } wb_entrada_t;

endpackage

// File: rtl/wb_fila2.sv
// Two-entry in-order FIFO of pending register writes; entry 0 is always the head.
module wb_fila2
  import estagio_wb_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  wb_entrada_t        dado_i,
  output logic [FILA_CW-1:0] count_o,
  output wb_entrada_t        cabeca_o
);

  fila_estado_e state_q, state_d;
  wb_entrada_t  e0_q, e0_d;
  wb_entrada_t  e1_q, e1_d;

  // State and storage registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= VAZIA;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  // Next occupancy and entry movement; a pop shifts entry 1 into the head slot.
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    unique case (state_q)
      VAZIA: begin
        if (push_i) begin
          e0_d    = dado_i;
          state_d = UMA;
        end
      end
      UMA: begin
        if (push_i && pop_i) begin
          e0_d = dado_i;
        end else if (push_i) begin
          e1_d    = dado_i;
          state_d = CHEIA;
        end else if (pop_i) begin
          state_d = VAZIA;
        end
      end
      CHEIA: begin
        if (pop_i) begin
          e0_d = e1_q;
          if (push_i) begin
            e1_d = dado_i;
          end else begin
            state_d = UMA;
          end
        end
      end
      default: state_d = VAZIA;
    endcase
  end

  assign count_o  = FILA_CW'(state_q);
  assign cabeca_o = e0_q;

endmodule

// File: rtl/estagio_wb.sv
// Write-back stage: selects the result, queues register writes, redirects fetch on jumps
// and squashes younger instructions for FLUSH_CICLOS cycles afterwards.
module estagio_wb
  import estagio_wb_pkg::*;
#(
  parameter int unsigned FLUSH_CICLOS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_saida_ula,
  input  logic [DATA_W-1:0] ex_saida_mem,
  input  logic              ex_sel_mem,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_escreve_reg,
  input  logic              ex_hab_jump,
  output logic              br_we,
  output logic [REG_AW-1:0] br_addr,
  output logic [DATA_W-1:0] br_data,
  input  logic              br_ready,
  output logic              pc_redir_valid,
  output logic [DATA_W-1:0] pc_redir_alvo,
  output logic [31:0]       instr_retiradas
);

  localparam int unsigned FLUSH_W = 3;
  localparam int unsigned CNT_W   = 32;

  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               redir_q, redir_d;
  logic [DATA_W-1:0]  alvo_q, alvo_d;
  logic [CNT_W-1:0]   ret_q, ret_d;

  logic [FILA_CW-1:0] fila_count;
  wb_entrada_t        fila_cabeca;
  wb_entrada_t        fila_entrada;
  logic               aceita;
  logic               push;
  logic               pop;

  // Ready depends only on registered state; while flushing everything is swallowed.
  assign ex_ready     = (fila_count < FILA_CW'(2)) || (flush_q != '0);
  assign aceita       = ex_valid && ex_ready && (flush_q == '0);
  assign push         = aceita && ex_escreve_reg && (ex_rd != '0) && !ex_hab_jump;
  assign br_we        = (fila_count != FILA_CW'(0));
  assign pop          = br_we && br_ready;
  assign fila_entrada = '{rd: ex_rd, dado: (ex_sel_mem ? ex_saida_mem : ex_saida_ula)};

  wb_fila2 u_fila (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_i   (push),
    .pop_i    (pop),
    .dado_i   (fila_entrada),
    .count_o  (fila_count),
    .cabeca_o (fila_cabeca)
  );

  assign br_addr         = fila_cabeca.rd;
  assign br_data         = fila_cabeca.dado;
  assign pc_redir_valid  = redir_q;
  assign pc_redir_alvo   = alvo_q;
  assign instr_retiradas = ret_q;

  // Flush countdown, one-cycle redirect pulse, sticky target and retire count.
  always_comb begin
    flush_d = flush_q;
    redir_d = 1'b0;
    alvo_d  = alvo_q;
    ret_d   = ret_q;
    if (flush_q != '0) begin
      flush_d = flush_q - FLUSH_W'(1);
    end
    if (aceita) begin
      ret_d = ret_q + CNT_W'(1);
      if (ex_hab_jump) begin
        redir_d = 1'b1;
        alvo_d  = ex_saida_ula;
        flush_d = FLUSH_W'(FLUSH_CICLOS);
      end
    end
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_q <= '0;
      redir_q <= 1'b0;
      alvo_q  <= '0;
      ret_q   <= '0;
    end else begin
      flush_q <= flush_d;
      redir_q <= redir_d;
      alvo_q  <= alvo_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: tb/tb_estagio_wb.sv
// Bench for estagio_wb: directed vector table, reset/wrap sequences, random traffic vs a queue model.
module tb_estagio_wb;
  import estagio_wb_pkg::*;

  localparam int unsigned FLUSH = 2;
  localparam int NVEC = 16;
  localparam int NRAND = 1500;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              ex_valid = 1'b0;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_saida_ula = '0;
  logic [DATA_W-1:0] ex_saida_mem = '0;
  logic              ex_sel_mem = 1'b0;
  logic [REG_AW-1:0] ex_rd = '0;
  logic              ex_escreve_reg = 1'b0;
  logic              ex_hab_jump = 1'b0;
  logic              br_we;
  logic [REG_AW-1:0] br_addr;
  logic [DATA_W-1:0] br_data;
  logic              br_ready = 1'b1;
  logic              pc_redir_valid;
  logic [DATA_W-1:0] pc_redir_alvo;
  logic [31:0]       instr_retiradas;

  estagio_wb #(.FLUSH_CICLOS(FLUSH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_saida_ula    (ex_saida_ula),
    .ex_saida_mem    (ex_saida_mem),
    .ex_sel_mem      (ex_sel_mem),
    .ex_rd           (ex_rd),
    .ex_escreve_reg  (ex_escreve_reg),
    .ex_hab_jump     (ex_hab_jump),
    .br_we           (br_we),
    .br_addr         (br_addr),
    .br_data         (br_data),
    .br_ready        (br_ready),
    .pc_redir_valid  (pc_redir_valid),
    .pc_redir_alvo   (pc_redir_alvo),
    .instr_retiradas (instr_retiradas)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nome, act, exp);
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] ula;
    logic [31:0] mem;
    logic        sel;
    logic        esc;
    logic        jmp;
    logic        brr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ready;
    logic        e_redir;
    logic [31:0] e_alvo;
    logic [31:0] e_ret;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [31:0] ula,
                              input logic [31:0] mem, input logic sel, input logic esc,
                              input logic jmp, input logic brr, input logic e_we,
                              input logic [4:0] e_addr, input logic [31:0] e_data,
                              input logic e_ready, input logic e_redir,
                              input logic [31:0] e_alvo, input logic [31:0] e_ret);
    vec_t r;
    r.valid = v; r.rd = rd; r.ula = ula; r.mem = mem; r.sel = sel; r.esc = esc;
    r.jmp = jmp; r.brr = brr; r.e_we = e_we; r.e_addr = e_addr; r.e_data = e_data;
    r.e_ready = e_ready; r.e_redir = e_redir; r.e_alvo = e_alvo; r.e_ret = e_ret;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] ula,
                       input logic [31:0] mem, input logic sel, input logic esc,
                       input logic jmp, input logic brr);
    ex_valid = v; ex_rd = rd; ex_saida_ula = ula; ex_saida_mem = mem;
    ex_sel_mem = sel; ex_escreve_reg = esc; ex_hab_jump = jmp; br_ready = brr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  vec_t tab[NVEC];

  // Queue-level reference model state.
  wb_entrada_t mq[$];
  int          flush_m;
  bit          redir_m;
  logic [31:0] alvo_m;
  logic [31:0] ret_m;

  initial begin
    // Each row: inputs held for one edge, then outputs expected right after that edge.
    //          v  rd     ula           mem           sel esc jmp brr  we addr  data          rdy redir alvo   ret
    tab[0]  = mk(1, 5'd3, 32'h1234,     32'h0,        0,  1,  0,  1,   1, 5'd3, 32'h1234,     1,  0,    32'h0,  32'd1);
    tab[1]  = mk(0, 5'd0, 32'h0,        32'h0,        0,  0,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h0,  32'd1);
    tab[2]  = mk(1, 5'd5, 32'h9999,     32'hCAFE,     1,  1,  0,  1,   1, 5'd5, 32'hCAFE,     1,  0,    32'h0,  32'd2);
    tab[3]  = mk(1, 5'd0, 32'h77,       32'h0,        0,  1,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h0,  32'd3);
    tab[4]  = mk(1, 5'd7, 32'h88,       32'h0,        0,  0,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h0,  32'd4);
    tab[5]  = mk(1, 5'd1, 32'h11,       32'h0,        0,  1,  0,  0,   1, 5'd1, 32'h11,       1,  0,    32'h0,  32'd5);
    tab[6]  = mk(1, 5'd2, 32'h22,       32'h0,        0,  1,  0,  0,   1, 5'd1, 32'h11,       0,  0,    32'h0,  32'd6);
    tab[7]  = mk(1, 5'd4, 32'h44,       32'h0,        0,  1,  0,  0,   1, 5'd1, 32'h11,       0,  0,    32'h0,  32'd6);
    tab[8]  = mk(0, 5'd0, 32'h0,        32'h0,        0,  0,  0,  1,   1, 5'd2, 32'h22,       1,  0,    32'h0,  32'd6);
    tab[9]  = mk(1, 5'd4, 32'h44,       32'h0,        0,  1,  0,  1,   1, 5'd4, 32'h44,       1,  0,    32'h0,  32'd7);
    tab[10] = mk(0, 5'd0, 32'h0,        32'h0,        0,  0,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h0,  32'd7);
    tab[11] = mk(1, 5'd9, 32'h40,       32'h0,        0,  1,  1,  1,   0, 5'd0, 32'h0,        1,  1,    32'h40, 32'd8);
    tab[12] = mk(1, 5'd10, 32'hA,       32'h0,        0,  1,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h40, 32'd8);
    tab[13] = mk(1, 5'd11, 32'hB,       32'h0,        0,  1,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h40, 32'd8);
    tab[14] = mk(1, 5'd12, 32'hC,       32'h0,        0,  1,  0,  1,   1, 5'd12, 32'hC,       1,  0,    32'h40, 32'd9);
    tab[15] = mk(0, 5'd0, 32'h0,        32'h0,        0,  0,  0,  1,   0, 5'd0, 32'h0,        1,  0,    32'h40, 32'd9);

    do_reset();
    chk("reset br_we", 32'(br_we), 32'd0);
    chk("reset br_addr", 32'(br_addr), 32'd0);
    chk("reset br_data", br_data, 32'd0);
    chk("reset redir", 32'(pc_redir_valid), 32'd0);
    chk("reset alvo", pc_redir_alvo, 32'd0);
    chk("reset retired", instr_retiradas, 32'd0);
    chk("reset ready", 32'(ex_ready), 32'd1);

    // Directed table.
    drive(tab[0].valid, tab[0].rd, tab[0].ula, tab[0].mem, tab[0].sel, tab[0].esc, tab[0].jmp, tab[0].brr);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      chk($sformatf("vec%0d br_we", i), 32'(br_we), 32'(tab[i].e_we));
      if (tab[i].e_we) begin
        chk($sformatf("vec%0d br_addr", i), 32'(br_addr), 32'(tab[i].e_addr));
        chk($sformatf("vec%0d br_data", i), br_data, tab[i].e_data);
      end
      chk($sformatf("vec%0d ex_ready", i), 32'(ex_ready), 32'(tab[i].e_ready));
      chk($sformatf("vec%0d redir", i), 32'(pc_redir_valid), 32'(tab[i].e_redir));
      chk($sformatf("vec%0d alvo", i), pc_redir_alvo, tab[i].e_alvo);
      chk($sformatf("vec%0d retired", i), instr_retiradas, tab[i].e_ret);
      if (i + 1 < NVEC)
        drive(tab[i+1].valid, tab[i+1].rd, tab[i+1].ula, tab[i+1].mem, tab[i+1].sel,
              tab[i+1].esc, tab[i+1].jmp, tab[i+1].brr);
      else
        idle();
    end

    // Reset in the middle of traffic with a full queue.
    drive(1'b1, 5'd6, 32'h66, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 5'd7, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("prefill ready", 32'(ex_ready), 32'd0);
    idle();
    br_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst br_we", 32'(br_we), 32'd0);
    chk("midrst br_addr", 32'(br_addr), 32'd0);
    chk("midrst br_data", br_data, 32'd0);
    chk("midrst redir", 32'(pc_redir_valid), 32'd0);
    chk("midrst alvo", pc_redir_alvo, 32'd0);
    chk("midrst retired", instr_retiradas, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    br_ready = 1'b1;
    @(negedge clock);
    chk("postrst br_we", 32'(br_we), 32'd0);
    chk("postrst ready", 32'(ex_ready), 32'd1);

    // Retire counter wrap.
    force dut.ret_q = 32'hFFFF_FFFF;
    #1;
    release dut.ret_q;
    chk("wrap preset", instr_retiradas, 32'hFFFF_FFFF);
    drive(1'b1, 5'd0, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    chk("wrap retired", instr_retiradas, 32'd0);
    idle();

    // Randomized traffic against the queue model.
    do_reset();
    mq.delete();
    flush_m = 0;
    redir_m = 1'b0;
    alvo_m = '0;
    ret_m = '0;
    for (int c = 0; c < NRAND; c++) begin
      logic        v, sel, esc, jmp, brr, rdy_m, acc;
      logic [4:0]  rd;
      logic [31:0] ula, mem;
      wb_entrada_t e;
      rdy_m = (mq.size() < 2) || (flush_m != 0);
      chk("rand br_we", 32'(br_we), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rand br_addr", 32'(br_addr), 32'(mq[0].rd));
        chk("rand br_data", br_data, mq[0].dado);
      end
      chk("rand ex_ready", 32'(ex_ready), 32'(rdy_m));
      chk("rand redir", 32'(pc_redir_valid), 32'(redir_m));
      chk("rand alvo", pc_redir_alvo, alvo_m);
      chk("rand retired", instr_retiradas, ret_m);

      v   = ($urandom_range(0, 9) < 7);
      rd  = 5'($urandom_range(0, 7));
      ula = $urandom;
      mem = $urandom;
      sel = 1'($urandom_range(0, 1));
      esc = ($urandom_range(0, 9) < 8);
      jmp = ($urandom_range(0, 9) == 0);
      brr = ($urandom_range(0, 9) < 5);
      drive(v, rd, ula, mem, sel, esc, jmp, brr);

      // Model update for the coming edge: drain first, then enqueue in order.
      acc = v && rdy_m && (flush_m == 0);
      if (mq.size() != 0 && brr) void'(mq.pop_front());
      redir_m = 1'b0;
      if (flush_m != 0) flush_m--;
      if (acc) begin
        ret_m = ret_m + 1;
        if (jmp) begin
          redir_m = 1'b1;
          alvo_m = ula;
          flush_m = FLUSH;
        end else if (esc && rd != 0) begin
          e.rd = rd;
          e.dado = sel ? mem : ula;
          mq.push_back(e);
        end
      end
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
